wcu_fire_scheduler: RTL and testbench
=====================================

Name: wcu_fire_scheduler

Overview:
- Arbitrates fire requests from NUM_REQ operator stations for the single shared weapons control unit.
- Grants one station at a time, round-robin, and issues a one-cycle fire_command to the WCU.
- Waits for the WCU's launch_missile acknowledge, or times out, then enforces a cooldown.
- Sits between the operator consoles and the WCU; consumes the WCU outputs launch_missile and remaining_missiles.

Parameters:
NUM_REQ, 4, number of requesting stations (2..8)
ACK_TIMEOUT, 15, cycles in WAIT_ACK before abandoning a shot (1..255)
COOLDOWN, 3, cycles spent in COOLDOWN after a successful launch (1..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
fire_req  input  NUM_REQ  level request per station
target_locked  input  1  radar lock status
launch_missile  input  1  WCU launch acknowledge
remaining_missiles  input  4  WCU missile count
fire_command  output  1  fire strobe to WCU
grant  output  NUM_REQ  one-hot owner of current shot, 0 when none
fire_done  output  NUM_REQ  one-cycle pulse to the station whose shot launched
fire_abort  output  NUM_REQ  one-cycle pulse to station(s) whose request failed
sched_state  output  2  IDLE=0, FIRE=1, WAIT_ACK=2, COOLDOWN=3

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - All outputs 0 and state IDLE.
  - Round-robin pointer ptr=0; timers 0.
  - Reset asserted mid-shot discards the shot; no done/abort pulse is issued.
- All registered outputs; no combinational path from inputs to outputs.
- IDLE:
  - If fire_req!=0, target_locked=1 and remaining_missiles!=0:
    - Select the first set bit searching ptr, ptr+1, ... mod NUM_REQ.
    - Next cycle: grant=onehot(sel), state FIRE.
  - If fire_req!=0 and remaining_missiles==0: fire_abort=fire_req for one cycle; stay IDLE.
  - If fire_req!=0 and target_locked=0 (and missiles remain): requests stay pending; no abort.
- FIRE:
  - fire_command=1 for exactly this one cycle; grant held; timer cleared.
  - Next state WAIT_ACK.
  - Latency: request sampled at edge k, fire_command high in the cycle after edge k+1.
- WAIT_ACK:
  - fire_command=0; timer increments each cycle.
  - launch_missile=1 sampled: fire_done[sel] pulses next cycle; grant cleared; ptr=(sel+1) mod NUM_REQ; state COOLDOWN.
  - Else, timer==ACK_TIMEOUT-1: fire_abort[sel] pulses next cycle; grant cleared; ptr advanced the same way; state IDLE.
  - Acknowledge and timeout on the same cycle: done wins.
  - Changes in target_locked and fire_req are ignored here; the WCU owns lock loss.
- COOLDOWN:
  - Exactly COOLDOWN cycles with fire_command=0 and grant=0, then IDLE.
  - New requests are held pending, not aborted.
- fire_req handling:
  - fire_req is level-sensitive.
  - A station should drop its request after its done/abort pulse.
  - A still-held request is re-arbitrated, and lower priority for one round because ptr has advanced.
  - Withdrawing a request after grant does not cancel the shot.
- launch_missile outside WAIT_ACK is ignored.
- At most one bit of grant and of fire_done is set in any cycle; fire_abort may have several bits set only in the no-missiles case.
- ptr wraps NUM_REQ-1 -> 0.

Test Plan:
- Single request: fire_req=0001, lock=1, missiles=4, WCU acks 2 cycles after the strobe.
  - Required: grant=0001, one fire_command pulse, fire_done=0001 pulse, then 3 COOLDOWN cycles, then IDLE.
- Round-robin: fire_req=1011 held continuously.
  - Required: grants in order 0001, 0010, 1000, 0001 across four shots, each separated by cooldown.
- Timeout: grant station 2 and never ack.
  - Required: fire_abort=0100 pulse exactly 15 cycles after WAIT_ACK entry, state back to IDLE, ptr=3.
- Empty magazine: remaining_missiles=0, fire_req=0110.
  - Required: fire_abort=0110 pulse, no fire_command, state stays IDLE.
- No lock: fire_req=0001 with lock=0 for 10 cycles, then lock=1.
  - Required: no abort during the 10 cycles; grant appears 1 cycle after lock rises.
- Reset mid-shot: assert rst=0 during WAIT_ACK.
  - Required: all outputs 0 immediately; no done/abort pulse; after release the first grant goes to station 0.

Source files
------------

// File: rtl/wcu_fire_scheduler.sv
// wcu_fire_scheduler
// Round-robin arbiter that hands the shared weapons control unit to one
// operator station at a time. It issues a single fire strobe, then waits for
// the WCU launch acknowledge or a timeout. After a successful launch it holds
// off new shots for a fixed cooldown.
//
// Handshake: fire_req is a level request. The station owning the shot sees
// grant held from arbitration until the shot resolves. The result is reported
// by a one-cycle pulse on fire_done (launched) or fire_abort (failed). A
// station is expected to drop fire_req after its pulse. A request that is
// still held is simply re-arbitrated.
//
// Every output is driven straight from a flop, so there is no combinational
// path from any input to any output.
module wcu_fire_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 15,
    parameter int COOLDOWN    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] fire_req,
    input  logic               target_locked,
    input  logic               launch_missile,
    input  logic [3:0]         remaining_missiles,
    output logic               fire_command,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] fire_done,
    output logic [NUM_REQ-1:0] fire_abort,
    output logic [1:0]         sched_state
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FIRE     = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_COOLDOWN = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] abort_q, abort_d;
    logic               fire_cmd_q, fire_cmd_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   sel_q, sel_d;
    logic [7:0]         timer_q, timer_d;
    logic [7:0]         cool_q, cool_d;

    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   ptr_adv;
    int                 scan_idx;

    // Search the request vector starting at ptr and wrapping modulo NUM_REQ.
    // The first set bit found is the winner.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = int'(ptr_q) + i;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!pick_found && fire_req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(scan_idx);
            end
        end
    end

    // The station after the current owner gets first priority next round.
    always_comb begin
        if (sel_q == PTR_W'(NUM_REQ - 1)) begin
            ptr_adv = '0;
        end else begin
            ptr_adv = sel_q + 1'b1;
        end
    end

    // Next-state and next-output logic for the shot sequencer.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        timer_d    = timer_q;
        cool_d     = cool_q;
        fire_cmd_d = 1'b0;
        done_d     = '0;
        abort_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (fire_req != '0) begin
                    if (remaining_missiles == 4'd0) begin
                        // Empty magazine: refuse every requester at once.
                        abort_d = fire_req;
                    end else if (target_locked && pick_found) begin
                        sel_d   = pick_idx;
                        grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        state_d = S_FIRE;
                    end
                    // Without a radar lock the request stays pending.
                end
            end

            S_FIRE: begin
                // The strobe is registered here, so it appears on the port
                // during the first WAIT_ACK cycle, one cycle wide.
                fire_cmd_d = 1'b1;
                timer_d    = '0;
                state_d    = S_WAIT_ACK;
            end

            S_WAIT_ACK: begin
                timer_d = timer_q + 8'd1;
                if (launch_missile) begin
                    // An acknowledge beats a timeout in the same cycle.
                    done_d  = grant_q;
                    grant_d = '0;
                    ptr_d   = ptr_adv;
                    cool_d  = '0;
                    state_d = S_COOLDOWN;
                end else if (timer_q == 8'(ACK_TIMEOUT - 1)) begin
                    abort_d = grant_q;
                    grant_d = '0;
                    ptr_d   = ptr_adv;
                    state_d = S_IDLE;
                end
            end

            S_COOLDOWN: begin
                if (cool_q == 8'(COOLDOWN - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    cool_d = cool_q + 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers. Reset discards any shot in flight and emits
    // no pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            done_q     <= '0;
            abort_q    <= '0;
            fire_cmd_q <= 1'b0;
            ptr_q      <= '0;
            sel_q      <= '0;
            timer_q    <= '0;
            cool_q     <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            fire_cmd_q <= fire_cmd_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            timer_q    <= timer_d;
            cool_q     <= cool_d;
        end
    end

    assign fire_command = fire_cmd_q;
    assign grant        = grant_q;
    assign fire_done    = done_q;
    assign fire_abort   = abort_q;
    assign sched_state  = state_q;

endmodule

// File: tb/tb_wcu_fire_scheduler.sv
// Directed testbench for wcu_fire_scheduler with NUM_REQ=4, ACK_TIMEOUT=15
// and COOLDOWN=3. Inputs are driven 1 ns after the rising edge, and outputs
// are sampled at the same point.
module tb_wcu_fire_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] fire_req;
    logic       target_locked;
    logic       launch_missile;
    logic [3:0] remaining_missiles;
    logic       fire_command;
    logic [3:0] grant;
    logic [3:0] fire_done;
    logic [3:0] fire_abort;
    logic [1:0] sched_state;

    int checks   = 0;
    int failures = 0;

    wcu_fire_scheduler #(
        .NUM_REQ    (4),
        .ACK_TIMEOUT(15),
        .COOLDOWN   (3)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .fire_req          (fire_req),
        .target_locked     (target_locked),
        .launch_missile    (launch_missile),
        .remaining_missiles(remaining_missiles),
        .fire_command      (fire_command),
        .grant             (grant),
        .fire_done         (fire_done),
        .fire_abort        (fire_abort),
        .sched_state       (sched_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst                = 1'b0;
        fire_req           = '0;
        target_locked      = 1'b0;
        launch_missile     = 1'b0;
        remaining_missiles = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    // Wait for a grant, bounded; n returns the number of edges waited.
    task automatic wait_grant(output int n);
        n = 0;
        while (grant == 4'b0000 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (grant == 4'b0000) begin
            failures++;
            $display("FAIL wait_grant_timeout got=%b required=nonzero", grant);
        end
    endtask

    // The grant has just appeared; fire, ack right after the strobe, and expect done.
    task automatic run_shot(input logic [3:0] exp, input string tag);
        checks++;
        if (grant !== exp) begin
            failures++;
            $display("FAIL %s_grant got=%b required=%b", tag, grant, exp);
        end
        step();
        checks++;
        if (fire_command !== 1'b1) begin
            failures++;
            $display("FAIL %s_strobe got=%b required=1", tag, fire_command);
        end
        launch_missile = 1'b1;
        step();
        launch_missile = 1'b0;
        checks++;
        if (fire_done !== exp) begin
            failures++;
            $display("FAIL %s_done got=%b required=%b", tag, fire_done, exp);
        end
        checks++;
        if (sched_state !== 2'd3) begin
            failures++;
            $display("FAIL %s_cooldown_state got=%0d required=3", tag, sched_state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        fire_req = '0;
        target_locked = 1'b0;
        launch_missile = 1'b0;
        remaining_missiles = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sched_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d required=0", sched_state); end
        checks++;
        if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b required=0000", grant); end
        checks++;
        if (fire_command !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b required=0", fire_command); end
        checks++;
        if (fire_done !== 4'b0000 || fire_abort !== 4'b0000) begin
            failures++;
            $display("FAIL reset_pulses got=%b/%b required=0000/0000", fire_done, fire_abort);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        apply_reset();
        fire_req = 4'b0001;
        target_locked = 1'b1;
        remaining_missiles = 4'd4;
        step();
        checks++;
        if (grant !== 4'b0001 || sched_state !== 2'd1) begin
            failures++;
            $display("FAIL single_grant got=%b/%0d required=0001/1", grant, sched_state);
        end
        checks++;
        if (fire_command !== 1'b0) begin failures++; $display("FAIL single_early_strobe got=%b required=0", fire_command); end
        step();
        checks++;
        if (fire_command !== 1'b1 || sched_state !== 2'd2) begin
            failures++;
            $display("FAIL single_strobe got=%b/%0d required=1/2", fire_command, sched_state);
        end
        step();
        checks++;
        if (fire_command !== 1'b0) begin failures++; $display("FAIL single_strobe_width got=%b required=0", fire_command); end
        launch_missile = 1'b1;
        step();
        launch_missile = 1'b0;
        checks++;
        if (fire_done !== 4'b0001 || grant !== 4'b0000 || sched_state !== 2'd3) begin
            failures++;
            $display("FAIL single_done got=%b/%b/%0d required=0001/0000/3", fire_done, grant, sched_state);
        end
        fire_req = 4'b0000;
        step();
        checks++;
        if (fire_done !== 4'b0000 || sched_state !== 2'd3) begin
            failures++;
            $display("FAIL single_cool1 got=%b/%0d required=0000/3", fire_done, sched_state);
        end
        step();
        checks++;
        if (sched_state !== 2'd3) begin failures++; $display("FAIL single_cool2 got=%0d required=3", sched_state); end
        step();
        checks++;
        if (sched_state !== 2'd0) begin failures++; $display("FAIL single_idle got=%0d required=0", sched_state); end
    endtask

    task automatic test_round_robin();
        int n;
        apply_reset();
        fire_req = 4'b1011;
        target_locked = 1'b1;
        remaining_missiles = 4'd4;
        wait_grant(n);
        run_shot(4'b0001, "rr1");
        wait_grant(n);
        checks++;
        if (n != 4) begin failures++; $display("FAIL rr_gap1 got=%0d required=4", n); end
        run_shot(4'b0010, "rr2");
        wait_grant(n);
        checks++;
        if (n != 4) begin failures++; $display("FAIL rr_gap2 got=%0d required=4", n); end
        run_shot(4'b1000, "rr3");
        wait_grant(n);
        run_shot(4'b0001, "rr4");
        fire_req = 4'b0000;
    endtask

    task automatic test_timeout();
        int bad;
        apply_reset();
        fire_req = 4'b0100;
        target_locked = 1'b1;
        remaining_missiles = 4'd4;
        step();
        step();
        bad = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (fire_abort !== 4'b0000 || sched_state !== 2'd2) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL timeout_early got=%0d bad cycles required=0", bad); end
        step();
        checks++;
        if (fire_abort !== 4'b0100 || sched_state !== 2'd0 || grant !== 4'b0000) begin
            failures++;
            $display("FAIL timeout_abort got=%b/%0d/%b required=0100/0/0000", fire_abort, sched_state, grant);
        end
        // ptr must now be 3, so station 3 wins when all four request.
        fire_req = 4'b1111;
        step();
        checks++;
        if (grant !== 4'b1000) begin failures++; $display("FAIL timeout_ptr got=%b required=1000", grant); end
        fire_req = 4'b0000;
    endtask

    task automatic test_ack_at_timeout();
        apply_reset();
        fire_req = 4'b0100;
        target_locked = 1'b1;
        remaining_missiles = 4'd4;
        step();
        step();
        repeat (14) step();
        launch_missile = 1'b1;
        step();
        launch_missile = 1'b0;
        checks++;
        if (fire_done !== 4'b0100 || fire_abort !== 4'b0000 || sched_state !== 2'd3) begin
            failures++;
            $display("FAIL ack_vs_timeout got=%b/%b/%0d required=0100/0000/3", fire_done, fire_abort, sched_state);
        end
        fire_req = 4'b0000;
    endtask

    task automatic test_empty();
        apply_reset();
        fire_req = 4'b0110;
        target_locked = 1'b1;
        remaining_missiles = 4'd0;
        step();
        checks++;
        if (fire_abort !== 4'b0110 || sched_state !== 2'd0 || grant !== 4'b0000) begin
            failures++;
            $display("FAIL empty_abort got=%b/%0d/%b required=0110/0/0000", fire_abort, sched_state, grant);
        end
        fire_req = 4'b0000;
        step();
        checks++;
        if (fire_abort !== 4'b0000 || fire_command !== 1'b0 || sched_state !== 2'd0) begin
            failures++;
            $display("FAIL empty_after got=%b/%b/%0d required=0000/0/0", fire_abort, fire_command, sched_state);
        end
    endtask

    task automatic test_no_lock();
        int bad;
        apply_reset();
        fire_req = 4'b0001;
        target_locked = 1'b0;
        remaining_missiles = 4'd4;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (fire_abort !== 4'b0000 || grant !== 4'b0000 || sched_state !== 2'd0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL nolock_pending got=%0d bad cycles required=0", bad); end
        target_locked = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0001) begin failures++; $display("FAIL nolock_grant got=%b required=0001", grant); end
        fire_req = 4'b0000;
    endtask

    task automatic test_stray_ack();
        int bad;
        apply_reset();
        remaining_missiles = 4'd4;
        target_locked = 1'b1;
        launch_missile = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (fire_done !== 4'b0000 || sched_state !== 2'd0) bad++;
        end
        launch_missile = 1'b0;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL stray_ack got=%0d bad cycles required=0", bad); end
    endtask

    task automatic test_reset_mid_shot();
        int n;
        int bad;
        apply_reset();
        fire_req = 4'b0100;
        target_locked = 1'b1;
        remaining_missiles = 4'd4;
        wait_grant(n);
        run_shot(4'b0100, "pre");
        wait_grant(n);
        step();
        step();
        checks++;
        if (sched_state !== 2'd2) begin failures++; $display("FAIL mid_in_wait got=%0d required=2", sched_state); end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || fire_command !== 1'b0 || sched_state !== 2'd0 ||
            fire_done !== 4'b0000 || fire_abort !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%b/%b/%0d/%b/%b required=0000/0/0/0000/0000",
                     grant, fire_command, sched_state, fire_done, fire_abort);
        end
        fire_req = 4'b1111;
        @(negedge clk);
        rst = 1'b1;
        step();
        bad = (fire_done !== 4'b0000 || fire_abort !== 4'b0000) ? 1 : 0;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL mid_no_pulse got=%b/%b required=0000/0000", fire_done, fire_abort); end
        checks++;
        if (grant !== 4'b0001) begin failures++; $display("FAIL mid_first_grant got=%b required=0001", grant); end
        fire_req = 4'b0000;
    endtask

    initial begin
        rst = 1'b0;
        fire_req = '0;
        target_locked = 1'b0;
        launch_missile = 1'b0;
        remaining_missiles = 4'd0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_ack_at_timeout();
        test_empty();
        test_no_lock();
        test_stray_ack();
        test_reset_mid_shot();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
